// File: rtl/ks_add_pipe.sv
// ks_add_pipe: fully pipelined Kogge-Stone adder/subtractor, one operation
// per cycle under a valid/ready handshake.
//
// Parameters
//   N      operand width, power of two, 4..256
//   TAG_W  width of the user tag carried with each operation (>= 1)
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   input handshake; a, b, cin, sub, tag_in are the operation
//   out_valid/out_ready output handshake; sum, cout, ovf, tag_out are the result
//   sub=0: a+b+cin      sub=1: a-b-cin (cout=1 means no borrow)
//
// Optional build macro KS_ADD_PIPE_SAT_EN adds input sat: when set and the
// operation overflows, sum clamps to the signed max/min instead of wrapping.
//
// Pipeline: stage 0 registers the conditioned p/g, stages 1..log2(N) are the
// prefix levels; sum/cout/ovf are formed combinationally from the last stage.
// A single enable (adv) moves every stage together.
module ks_add_pipe #(
    parameter int N     = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag_in,
`ifdef KS_ADD_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] tag_out
);
    localparam int LOG = $clog2(N);

    // Index k holds stage k; stage LOG drives the outputs.
    logic [N-1:0]     g_q   [LOG+1];
    logic [N-1:0]     p_q   [LOG+1];
    logic [N-1:0]     pr_q  [LOG+1];
    logic             c0_q  [LOG+1];
    logic [TAG_W-1:0] tag_q [LOG+1];
    logic             vld_q [LOG+1];

    logic [N-1:0]     g_nx   [LOG+1];
    logic [N-1:0]     p_nx   [LOG+1];
    logic [N-1:0]     pr_nx  [LOG+1];
    logic             c0_nx  [LOG+1];
    logic [TAG_W-1:0] tag_nx [LOG+1];
    logic             vld_nx [LOG+1];

`ifdef KS_ADD_PIPE_SAT_EN
    logic             sat_q  [LOG+1];
    logic             sat_nx [LOG+1];
`endif

    logic         adv;
    logic         c0;
    logic [N-1:0] b_eff;
    logic [N-1:0] p0;
    logic [N-1:0] g0;
    logic [N-1:0] carry;
    logic [N-1:0] raw;

    assign adv      = !vld_q[LOG] || out_ready;
    assign in_ready = adv;

    always_comb begin
        c0    = cin ^ sub;
        b_eff = sub ? ~b : b;
        p0    = a ^ b_eff;
        g0    = a & b_eff;
        // The carry-in acts as the generate of bit -1; merging it into bit 0
        // here means each prefix group G[i] already includes it, so carry
        // into bit i+1 is simply G[i].
        g0[0] = g0[0] | (p0[0] & c0);
    end

    always_comb begin
        g_nx[0]   = g0;
        p_nx[0]   = p0;
        pr_nx[0]  = p0;
        c0_nx[0]  = c0;
        tag_nx[0] = tag_in;
        vld_nx[0] = in_valid;
`ifdef KS_ADD_PIPE_SAT_EN
        sat_nx[0] = sat;
`endif
        for (int unsigned k = 1; k <= LOG; k++) begin
            g_nx[k]   = g_q[k-1];
            p_nx[k]   = p_q[k-1];
            pr_nx[k]  = pr_q[k-1];
            c0_nx[k]  = c0_q[k-1];
            tag_nx[k] = tag_q[k-1];
            vld_nx[k] = vld_q[k-1];
`ifdef KS_ADD_PIPE_SAT_EN
            sat_nx[k] = sat_q[k-1];
`endif
            // Level k combines each bit with the group 2^(k-1) below it.
            for (int unsigned i = (1 << (k - 1)); i < N; i++) begin
                g_nx[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i - (1 << (k - 1))]);
                p_nx[k][i] = p_q[k-1][i] & p_q[k-1][i - (1 << (k - 1))];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k <= LOG; k++) begin
                g_q[k]   <= '0;
                p_q[k]   <= '0;
                pr_q[k]  <= '0;
                c0_q[k]  <= 1'b0;
                tag_q[k] <= '0;
                vld_q[k] <= 1'b0;
`ifdef KS_ADD_PIPE_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end
        end else if (adv) begin
            g_q   <= g_nx;
            p_q   <= p_nx;
            pr_q  <= pr_nx;
            c0_q  <= c0_nx;
            tag_q <= tag_nx;
            vld_q <= vld_nx;
`ifdef KS_ADD_PIPE_SAT_EN
            sat_q <= sat_nx;
`endif
        end
    end

    assign carry     = {g_q[LOG][N-2:0], c0_q[LOG]};
    assign raw       = pr_q[LOG] ^ carry;
    assign cout      = g_q[LOG][N-1];
    assign ovf       = g_q[LOG][N-1] ^ g_q[LOG][N-2];
    assign out_valid = vld_q[LOG];
    assign tag_out   = tag_q[LOG];

`ifdef KS_ADD_PIPE_SAT_EN
    // On overflow the wrapped sign bit is the inverse of the true sign.
    assign sum = (sat_q[LOG] && ovf) ? {~raw[N-1], {(N-1){raw[N-1]}}} : raw;
`else
    assign sum = raw;
`endif

endmodule

// File: tb/tb_ks_add_pipe.sv
// tb_ks_add_pipe: directed and randomised checks of ks_add_pipe using three
// instances (N=64, N=8, N=32) on a shared clock and reset.
// With KS_ADD_PIPE_SAT_EN defined, the saturation cases are also exercised.
module tb_ks_add_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- N=64 instance ----------------
    logic        d64_in_valid = 1'b0, d64_in_ready, d64_cin = 1'b0, d64_sub = 1'b0;
    logic [63:0] d64_a = '0, d64_b = '0, d64_sum;
    logic [3:0]  d64_tag = '0, d64_tag_out;
    logic        d64_out_valid, d64_out_ready = 1'b1, d64_cout, d64_ovf;
    // ---------------- N=8 instance -----------------
    logic        d8_in_valid = 1'b0, d8_in_ready, d8_cin = 1'b0, d8_sub = 1'b0;
    logic [7:0]  d8_a = '0, d8_b = '0, d8_sum;
    logic [3:0]  d8_tag = '0, d8_tag_out;
    logic        d8_out_valid, d8_out_ready = 1'b1, d8_cout, d8_ovf;
    // ---------------- N=32 instance ----------------
    logic        d32_in_valid = 1'b0, d32_in_ready, d32_cin = 1'b0, d32_sub = 1'b0;
    logic [31:0] d32_a = '0, d32_b = '0, d32_sum;
    logic [3:0]  d32_tag = '0, d32_tag_out;
    logic        d32_out_valid, d32_out_ready = 1'b1, d32_cout, d32_ovf;
`ifdef KS_ADD_PIPE_SAT_EN
    logic        d64_sat = 1'b0, d8_sat = 1'b0, d32_sat = 1'b0;
`endif

    ks_add_pipe #(.N(64), .TAG_W(4)) u_d64 (
        .clk(clk), .rst(rst), .in_valid(d64_in_valid), .in_ready(d64_in_ready),
        .a(d64_a), .b(d64_b), .cin(d64_cin), .sub(d64_sub), .tag_in(d64_tag),
`ifdef KS_ADD_PIPE_SAT_EN
        .sat(d64_sat),
`endif
        .out_valid(d64_out_valid), .out_ready(d64_out_ready), .sum(d64_sum),
        .cout(d64_cout), .ovf(d64_ovf), .tag_out(d64_tag_out)
    );

    ks_add_pipe #(.N(8), .TAG_W(4)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
        .a(d8_a), .b(d8_b), .cin(d8_cin), .sub(d8_sub), .tag_in(d8_tag),
`ifdef KS_ADD_PIPE_SAT_EN
        .sat(d8_sat),
`endif
        .out_valid(d8_out_valid), .out_ready(d8_out_ready), .sum(d8_sum),
        .cout(d8_cout), .ovf(d8_ovf), .tag_out(d8_tag_out)
    );

    ks_add_pipe #(.N(32), .TAG_W(4)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(d32_in_valid), .in_ready(d32_in_ready),
        .a(d32_a), .b(d32_b), .cin(d32_cin), .sub(d32_sub), .tag_in(d32_tag),
`ifdef KS_ADD_PIPE_SAT_EN
        .sat(d32_sat),
`endif
        .out_valid(d32_out_valid), .out_ready(d32_out_ready), .sum(d32_sum),
        .cout(d32_cout), .ovf(d32_ovf), .tag_out(d32_tag_out)
    );

    typedef struct packed {
        logic [3:0]  tag;
        logic        ovf;
        logic        cout;
        logic [31:0] sum;
    } res_t;

    res_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Reference: widened add of conditioned operands; overflow from operand signs.
    function automatic res_t ref32(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sb, input logic [3:0] t);
        logic [31:0] bb;
        logic [32:0] s;
        res_t        r;
        bb     = sb ? ~b : b;
        s      = {1'b0, a} + {1'b0, bb} + {32'd0, ci ^ sb};
        r.sum  = s[31:0];
        r.cout = s[32];
        r.ovf  = (a[31] == bb[31]) && (s[31] != a[31]);
        r.tag  = t;
        return r;
    endfunction

    // Present one op on the N=8 instance and return #1 after the capturing edge.
    task automatic d8_send(input logic [7:0] av, input logic [7:0] bv,
                           input logic ci, input logic sb, input logic [3:0] t);
        d8_a = av; d8_b = bv; d8_cin = ci; d8_sub = sb; d8_tag = t;
        d8_in_valid = 1'b1;
        @(posedge clk); #1;
        d8_in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   sent;
        int   got;
        int   recv;
        logic acc;
        logic [7:0] fa [4];
        logic [7:0] fb [4];
        logic [7:0] fs [4];
        logic       fc [4];
        logic       fo [4];
        logic [3:0] ft [4];
        res_t       e;

        fa = '{8'h01, 8'h22, 8'hF0, 8'h80};
        fb = '{8'h01, 8'h11, 8'h20, 8'h80};
        fs = '{8'h02, 8'h33, 8'h10, 8'h00};
        fc = '{1'b0, 1'b0, 1'b1, 1'b1};
        fo = '{1'b0, 1'b0, 1'b0, 1'b1};
        ft = '{4'hA, 4'hB, 4'hC, 4'hD};

        // ---- reset state ----
        #2;
        chk("rst_out_valid", {63'd0, d8_out_valid}, 64'd0);
        chk("rst_sum",       {56'd0, d8_sum}, 64'd0);
        chk("rst_cout_ovf",  {62'd0, d8_cout, d8_ovf}, 64'd0);
        chk("rst_tag",       {60'd0, d8_tag_out}, 64'd0);
        chk("rst64_valid",   {63'd0, d64_out_valid}, 64'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("in_ready_after_rst", {63'd0, d8_in_ready}, 64'd1);
        @(posedge clk); #1;

        // ---- N=64 latency: all-ones + 1 ----
        d64_a = '1; d64_b = 64'd1; d64_cin = 1'b0; d64_sub = 1'b0; d64_tag = 4'h5;
        d64_in_valid = 1'b1;
        @(posedge clk); #1;
        d64_in_valid = 1'b0;
        cyc = 1;
        while (!d64_out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("n64_latency", 64'(cyc), 64'd7);
        chk("n64_sum",     d64_sum, 64'd0);
        chk("n64_cout",    {63'd0, d64_cout}, 64'd1);
        chk("n64_ovf",     {63'd0, d64_ovf}, 64'd0);
        chk("n64_tag",     {60'd0, d64_tag_out}, 64'h5);

        // ---- N=8 back-to-back stream ----
        d8_send(8'h7F, 8'h01, 1'b0, 1'b0, 4'h1);
        d8_send(8'h10, 8'h20, 1'b0, 1'b1, 4'h2);
        d8_send(8'h05, 8'h03, 1'b1, 1'b1, 4'h3);
        @(posedge clk); #1;
        chk("s1_valid", {63'd0, d8_out_valid}, 64'd1);
        chk("s1_res",   {50'd0, d8_tag_out, d8_cout, d8_ovf, d8_sum}, {50'd0, 4'h1, 1'b0, 1'b1, 8'h80});
        @(posedge clk); #1;
        chk("s2_valid", {63'd0, d8_out_valid}, 64'd1);
        chk("s2_res",   {50'd0, d8_tag_out, d8_cout, d8_ovf, d8_sum}, {50'd0, 4'h2, 1'b0, 1'b0, 8'hF0});
        @(posedge clk); #1;
        chk("s3_valid", {63'd0, d8_out_valid}, 64'd1);
        chk("s3_res",   {50'd0, d8_tag_out, d8_cout, d8_ovf, d8_sum}, {50'd0, 4'h3, 1'b1, 1'b0, 8'h01});
        @(posedge clk); #1;
        chk("s_drained", {63'd0, d8_out_valid}, 64'd0);

        // ---- N=8 backpressure: fill, hold 10 cycles, release ----
        d8_out_ready = 1'b0;
        sent = 0;
        cyc  = 0;
        while (sent < 4 && cyc < 12) begin
            d8_a = fa[sent]; d8_b = fb[sent]; d8_cin = 1'b0; d8_sub = 1'b0; d8_tag = ft[sent];
            d8_in_valid = 1'b1;
            #1;
            acc = d8_in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        chk("fill_count", 64'(sent), 64'd4);
        // A fifth op waits on the input; it must not be taken while full.
        d8_a = 8'h55; d8_b = 8'h11; d8_tag = 4'h9; d8_in_valid = 1'b1;
        #1;
        chk("full_in_ready", {63'd0, d8_in_ready}, 64'd0);
        chk("full_valid",    {63'd0, d8_out_valid}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_in_ready", {63'd0, d8_in_ready}, 64'd0);
            chk("hold_sum",      {56'd0, d8_sum}, 64'h02);
            chk("hold_tag",      {60'd0, d8_tag_out}, 64'hA);
        end
        d8_in_valid  = 1'b0;
        d8_out_ready = 1'b1;
        #1;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 20) begin
            if (d8_out_valid) begin
                chk("drain_res", {50'd0, d8_tag_out, d8_cout, d8_ovf, d8_sum},
                    {50'd0, ft[got], fc[got], fo[got], fs[got]});
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("drain_count", 64'(got), 64'd4);
        chk("drain_empty", {63'd0, d8_out_valid}, 64'd0);

        // ---- N=8 reset while ops are in flight ----
        d8_send(8'h01, 8'h02, 1'b0, 1'b0, 4'h1);
        d8_send(8'h03, 8'h04, 1'b0, 1'b0, 4'h2);
        d8_send(8'h05, 8'h06, 1'b0, 1'b0, 4'h3);
        @(posedge clk); #1;
        chk("pre_rst_valid", {63'd0, d8_out_valid}, 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {63'd0, d8_out_valid}, 64'd0);
        chk("mid_rst_tag",   {60'd0, d8_tag_out}, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_valid", {63'd0, d8_out_valid}, 64'd0);
        d8_send(8'h40, 8'h02, 1'b0, 1'b0, 4'h7);
        cyc = 1;
        while (!d8_out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("post_rst_latency", 64'(cyc), 64'd4);
        chk("post_rst_res", {50'd0, d8_tag_out, d8_cout, d8_ovf, d8_sum}, {50'd0, 4'h7, 1'b0, 1'b0, 8'h42});
        @(posedge clk); #1;
        chk("post_rst_single", {63'd0, d8_out_valid}, 64'd0);

`ifdef KS_ADD_PIPE_SAT_EN
        // ---- saturation ----
        d8_sat = 1'b1; d8_send(8'h7F, 8'h7F, 1'b0, 1'b0, 4'h1);
        d8_sat = 1'b1; d8_send(8'h80, 8'hFF, 1'b0, 1'b0, 4'h2);
        d8_sat = 1'b0; d8_send(8'h80, 8'hFF, 1'b0, 1'b0, 4'h3);
        @(posedge clk); #1;
        chk("sat_pos", {50'd0, d8_tag_out, d8_cout, d8_ovf, d8_sum}, {50'd0, 4'h1, 1'b0, 1'b1, 8'h7F});
        @(posedge clk); #1;
        chk("sat_neg", {50'd0, d8_tag_out, d8_cout, d8_ovf, d8_sum}, {50'd0, 4'h2, 1'b1, 1'b1, 8'h80});
        @(posedge clk); #1;
        chk("sat_off", {50'd0, d8_tag_out, d8_cout, d8_ovf, d8_sum}, {50'd0, 4'h3, 1'b1, 1'b1, 8'h7F});
`endif

        // ---- N=32 randomised stream with random stalls ----
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 10000 && cyc < 60000) begin
            if (!d32_in_valid && sent < 10000 && $urandom_range(0, 3) != 0) begin
                d32_a   = $urandom;
                d32_b   = $urandom;
                d32_cin = 1'($urandom_range(0, 1));
                d32_sub = 1'($urandom_range(0, 1));
                d32_tag = 4'(sent);
                d32_in_valid = 1'b1;
            end
            d32_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (d32_out_valid && d32_out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected", {63'd0, d32_out_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_res", {26'd0, d32_tag_out, d32_ovf, d32_cout, d32_sum}, {26'd0, e});
                end
                recv++;
            end
            acc = d32_in_valid && d32_in_ready;
            if (acc) exp_q.push_back(ref32(d32_a, d32_b, d32_cin, d32_sub, d32_tag));
            @(posedge clk); #1;
            if (acc) begin
                d32_in_valid = 1'b0;
                sent++;
            end
            cyc++;
        end
        chk("rnd_count", 64'(recv), 64'd10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
